// File: rtl/inst_fetch_unit_if.sv
// Instruction memory request/response channel between the fetch unit and instruction memory.
// The fetch unit is the master; the memory answers with ack and, later or in the same cycle, rvalid/rdata.
interface inst_fetch_unit_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic        rvalid;
   logic [31:0] rdata;

   modport master (
      output req,
      output addr,
      input  ack,
      input  rvalid,
      input  rdata
   );

   modport slave (
      input  req,
      input  addr,
      output ack,
      output rvalid,
      output rdata
   );
endinterface

// File: rtl/inst_fetch_unit.sv
// Instruction fetch stage: owns the PC, fetches one word at a time from instruction memory,
// holds it in the instruction register until retired, then selects the next PC.
//
// state  | meaning
// S_REQ  | request outstanding on imem, address = pc, waiting for ack
// S_WAIT | request acked, waiting for rvalid
// S_HOLD | inst holds a fetched, unretired instruction (inst_valid = 1)
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                      clk,
   input  logic                      rst,
   inst_fetch_unit_if.master         imem,
   output logic [31:0]               inst,
   output logic                      inst_valid,
   input  logic                      inst_ready,
   output logic [31:0]               pc,
   output logic [31:0]               pc_plus4,
   input  logic                      pcsrc,
   input  logic                      jump,
   input  logic [31:0]               branch_target
);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } state_t;

   localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

   state_t      state;
   logic [31:0] pc_next;
   logic        unused_bits;

   always_comb begin
      pc_plus4 = pc + 32'd4;
   end

   // Jump beats branch when both are flagged for the same instruction.
   always_comb begin
      pc_next = pc_plus4;
      if (jump) begin
         pc_next = {pc_plus4[31:28], inst[25:0], 2'b00};
      end else if (pcsrc) begin
         pc_next = {branch_target[31:2], 2'b00};
      end
   end

   // Request is gated by rst so nothing is issued while reset is held.
   assign imem.req  = (state == S_REQ) && !rst;
   assign imem.addr = pc;

   assign unused_bits = ^branch_target[1:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_REQ;
         pc         <= RESET_PC_ALIGNED;
         inst       <= 32'h0;
         inst_valid <= 1'b0;
      end else begin
         case (state)
            S_REQ: begin
               if (imem.ack) begin
                  if (imem.rvalid) begin
                     inst       <= imem.rdata;
                     inst_valid <= 1'b1;
                     state      <= S_HOLD;
                  end else begin
                     state      <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (imem.rvalid) begin
                  inst       <= imem.rdata;
                  inst_valid <= 1'b1;
                  state      <= S_HOLD;
               end
            end
            S_HOLD: begin
               if (inst_ready) begin
                  pc         <= pc_next;
                  inst_valid <= 1'b0;
                  state      <= S_REQ;
               end
            end
            default: begin
               state      <= S_REQ;
               inst_valid <= 1'b0;
            end
         endcase
      end
   end

endmodule
